// File: rtl/ex_mem_pipe_stage_pkg.sv
// Shared definitions for the EX->MEM pipeline stage: core default widths, the zero-register
// address and the skid-buffer occupancy encoding.
package ex_mem_pipe_stage_pkg;

    localparam int unsigned CORE_DATA_W = 32;
    localparam int unsigned CORE_ADDR_W = 5;
    localparam logic [4:0]  REG_ZERO    = 5'd0;

    typedef enum logic [1:0] {
        OccEmpty,
        OccOne,
        OccFull
    } occ_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline buffer: 2-entry skid with registered ready (SKID=1) or a
// single slot with combinational ready (SKID=0). Synchronous flush drops everything held.
module pipe_skid_buf
    import ex_mem_pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o
);

    logic              push;
    logic              pop;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;

    assign push        = in_valid_i & in_ready_o;
    assign pop         = m_valid & out_ready_i;
    assign out_valid_o = m_valid;
    assign out_data_o  = m_data;

    if (SKID) begin : g_skid
        occ_e              occ_q, occ_d;
        logic              ready_q, ready_d;
        logic [DATA_W-1:0] m_data_q, m_data_d;
        logic [DATA_W-1:0] s_data_q, s_data_d;

        always_comb begin
            occ_d    = occ_q;
            m_data_d = m_data_q;
            s_data_d = s_data_q;
            unique case (occ_q)
                OccEmpty: begin
                    if (push) begin
                        occ_d    = OccOne;
                        m_data_d = in_data_i;
                    end
                end
                OccOne: begin
                    if (push && pop) begin
                        m_data_d = in_data_i;
                    end else if (push) begin
                        occ_d    = OccFull;
                        s_data_d = in_data_i;
                    end else if (pop) begin
                        occ_d = OccEmpty;
                    end
                end
                OccFull: begin
                    if (pop) begin
                        occ_d    = OccOne;
                        m_data_d = s_data_q;
                    end
                end
                default: occ_d = OccEmpty;
            endcase
            if (flush_i) begin
                occ_d = OccEmpty;
            end
        end

        // Ready is a flop so the EX stage never sees a combinational path from MEM ready.
        assign ready_d = (occ_d != OccFull);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                occ_q    <= OccEmpty;
                ready_q  <= 1'b1;
                m_data_q <= '0;
                s_data_q <= '0;
            end else begin
                occ_q    <= occ_d;
                ready_q  <= ready_d;
                m_data_q <= m_data_d;
                s_data_q <= s_data_d;
            end
        end

        assign in_ready_o = ready_q;
        assign m_valid    = (occ_q != OccEmpty);
        assign m_data     = m_data_q;
    end else begin : g_single
        logic              m_valid_q, m_valid_d;
        logic [DATA_W-1:0] m_data_q, m_data_d;

        always_comb begin
            m_valid_d = m_valid_q;
            m_data_d  = m_data_q;
            if (push) begin
                m_valid_d = 1'b1;
                m_data_d  = in_data_i;
            end else if (pop) begin
                m_valid_d = 1'b0;
            end
            if (flush_i) begin
                m_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                m_valid_q <= 1'b0;
                m_data_q  <= '0;
            end else begin
                m_valid_q <= m_valid_d;
                m_data_q  <= m_data_d;
            end
        end

        assign in_ready_o = ~m_valid_q | out_ready_i;
        assign m_valid    = m_valid_q;
        assign m_data     = m_data_q;
    end

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage: packs {wen, waddr, op_c} through a valid/ready buffer and
// suppresses write enables aimed at the zero register.
module ex_mem_pipe_stage
    import ex_mem_pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W = CORE_DATA_W,
    parameter int unsigned ADDR_W = CORE_ADDR_W,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [DATA_W-1:0] ex_op_c_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic              ex_wen_i,
    output logic              mem_valid_o,
    input  logic              mem_ready_i,
    output logic [DATA_W-1:0] mem_op_c_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic              mem_wen_o
);

    localparam int unsigned EntryW = DATA_W + ADDR_W + 1;

    logic [EntryW-1:0] in_entry;
    logic [EntryW-1:0] out_entry;
    logic              out_valid;

    assign in_entry = {ex_wen_i, ex_waddr_i, ex_op_c_i};

    pipe_skid_buf #(
        .DATA_W (EntryW),
        .SKID   (SKID)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (ex_valid_i),
        .in_ready_o  (ex_ready_o),
        .in_data_i   (in_entry),
        .out_valid_o (out_valid),
        .out_ready_i (mem_ready_i),
        .out_data_o  (out_entry)
    );

    assign mem_valid_o = out_valid;
    assign mem_op_c_o  = out_entry[DATA_W-1:0];
    assign mem_waddr_o = out_entry[DATA_W +: ADDR_W];
    assign mem_wen_o   = out_valid & out_entry[EntryW-1] & (mem_waddr_o != ADDR_W'(REG_ZERO));

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench: drives a SKID=1 and a SKID=0 instance from shared stimulus, each
// checked against a FIFO-of-accepted-entries model by a free-running monitor.
module tb_ex_mem_pipe_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        fl, v, w, rdy;
    logic [31:0] d;
    logic [4:0]  a;

    logic        er [2];
    logic        mv [2];
    logic        mw [2];
    logic [31:0] mo [2];
    logic [4:0]  ma [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [37:0] q0[$];
    logic [37:0] q1[$];
    bit          pushed [2];

    always #5 clk = ~clk;

    ex_mem_pipe_stage #(.DATA_W(32), .ADDR_W(5), .SKID(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(fl), .ex_valid_i(v), .ex_ready_o(er[0]),
        .ex_op_c_i(d), .ex_waddr_i(a), .ex_wen_i(w), .mem_valid_o(mv[0]),
        .mem_ready_i(rdy), .mem_op_c_o(mo[0]), .mem_waddr_o(ma[0]), .mem_wen_o(mw[0])
    );

    ex_mem_pipe_stage #(.DATA_W(32), .ADDR_W(5), .SKID(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush_i(fl), .ex_valid_i(v), .ex_ready_o(er[1]),
        .ex_op_c_i(d), .ex_waddr_i(a), .ex_wen_i(w), .mem_valid_o(mv[1]),
        .mem_ready_i(rdy), .mem_op_c_o(mo[1]), .mem_waddr_o(ma[1]), .mem_wen_o(mw[1])
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic mdl_push(input int i, input logic [37:0] e);
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    function automatic int mdl_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [37:0] mdl_front(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    task automatic mdl_pop(input int i);
        if (i == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
    endtask

    task automatic mdl_clear(input int i);
        if (i == 0) q0.delete();
        else q1.delete();
    endtask

    // One cycle: apply inputs after the falling edge, then log what each DUT accepts.
    task automatic step(input logic vv, input logic [31:0] dd, input logic [4:0] aa,
                        input logic ww, input logic rr, input logic ff);
        @(negedge clk);
        v = vv; d = dd; a = aa; w = ww; rdy = rr; fl = ff;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (v && er[i]) begin
                mdl_push(i, {w && (a != 5'd0), a, d});
                pushed[i] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        int          held;
        logic        exp_rdy;
        logic [37:0] head;
        #2;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mdl_clear(i);
                pushed[i] = 1'b0;
            end else begin
                held    = mdl_size(i) - (pushed[i] ? 1 : 0);
                exp_rdy = (i == 1) ? (held < 2) : (held == 0 || rdy);
                check($sformatf("mon_valid[%0d]", i), 64'(mv[i]), 64'(held > 0));
                check($sformatf("mon_ready[%0d]", i), 64'(er[i]), 64'(exp_rdy));
                if (held > 0) begin
                    head = mdl_front(i);
                    check($sformatf("mon_entry[%0d]", i), 64'({mw[i], ma[i], mo[i]}), 64'(head));
                    if (rdy) mdl_pop(i);
                end
                if (fl) mdl_clear(i);
                pushed[i] = 1'b0;
            end
        end
    end

    initial begin
        rst = 1'b1; v = 0; d = 0; a = 0; w = 0; rdy = 0; fl = 0;
        pushed[0] = 0; pushed[1] = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", 64'(mv[i]), 64'd0);
            check("rst_opc",   64'(mo[i]), 64'd0);
            check("rst_waddr", 64'(ma[i]), 64'd0);
            check("rst_wen",   64'(mw[i]), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("rel_ready1", 64'(er[1]), 64'd1);
        check("rel_ready0", 64'(er[0]), 64'd1);

        // Streaming at full rate.
        step(1, 32'h11, 5'd1, 1, 1, 0);
        check("strm_rdy1", 64'(er[1]), 64'd1);
        step(1, 32'h22, 5'd1, 1, 1, 0);
        check("strm_out1_11", 64'(mo[1]), 64'h11);
        check("strm_out0_11", 64'(mo[0]), 64'h11);
        step(1, 32'h33, 5'd1, 1, 1, 0);
        check("strm_out1_22", 64'(mo[1]), 64'h22);
        check("strm_rdy1b",   64'(er[1]), 64'd1);
        step(0, 32'h0, 5'd0, 0, 1, 0);
        check("strm_out1_33", 64'(mo[1]), 64'h33);
        step(0, 32'h0, 5'd0, 0, 1, 0);
        check("strm_drained", 64'(mv[1]), 64'd0);

        // Backpressure fills the skid; single-slot ready follows mem_ready combinationally.
        step(1, 32'hA, 5'd2, 1, 0, 0);
        step(1, 32'hB, 5'd2, 1, 0, 0);
        check("bp_rdy1_one",  64'(er[1]), 64'd1);
        check("bp_rdy0_held", 64'(er[0]), 64'd0);
        step(0, 32'h0, 5'd0, 0, 0, 0);
        check("bp_rdy1_full", 64'(er[1]), 64'd0);
        check("bp_hold1_A",   64'(mo[1]), 64'hA);
        check("bp_hold0_A",   64'(mo[0]), 64'hA);
        step(0, 32'h0, 5'd0, 0, 0, 0);
        check("bp_stable1_A", 64'(mo[1]), 64'hA);
        step(0, 32'h0, 5'd0, 0, 1, 0);
        check("bp_rdy0_comb", 64'(er[0]), 64'd1);
        step(0, 32'h0, 5'd0, 0, 1, 0);
        check("bp_out1_B",    64'(mo[1]), 64'hB);
        check("bp_rdy1_back", 64'(er[1]), 64'd1);
        check("bp_empty0",    64'(mv[0]), 64'd0);
        step(0, 32'h0, 5'd0, 0, 1, 0);
        check("bp_empty1",    64'(mv[1]), 64'd0);

        // Writes to x0 are suppressed.
        step(1, 32'h44, 5'd0, 1, 1, 0);
        step(1, 32'h55, 5'd5, 1, 1, 0);
        check("x0_valid1", 64'(mv[1]), 64'd1);
        check("x0_wen1",   64'(mw[1]), 64'd0);
        check("x0_wen0",   64'(mw[0]), 64'd0);
        step(0, 32'h0, 5'd0, 0, 1, 0);
        check("x5_wen1",   64'(mw[1]), 64'd1);
        check("x5_waddr1", 64'(ma[1]), 64'd5);
        check("x5_wen0",   64'(mw[0]), 64'd1);

        // Flush while full with an incoming entry offered.
        step(1, 32'h66, 5'd3, 1, 0, 0);
        step(1, 32'h77, 5'd3, 1, 0, 0);
        step(1, 32'h88, 5'd3, 1, 0, 1);
        check("fl_full_rdy1", 64'(er[1]), 64'd0);
        step(0, 32'h0, 5'd0, 0, 0, 0);
        check("fl_valid1", 64'(mv[1]), 64'd0);
        check("fl_rdy1",   64'(er[1]), 64'd1);
        check("fl_valid0", 64'(mv[0]), 64'd0);
        check("fl_rdy0",   64'(er[0]), 64'd1);
        step(0, 32'h0, 5'd0, 0, 1, 0);
        check("fl_absent1", 64'(mv[1]), 64'd0);

        // Asynchronous reset in the middle of a held entry.
        step(1, 32'h99, 5'd7, 1, 0, 0);
        step(0, 32'h0, 5'd0, 0, 0, 0);
        #2;
        rst = 1'b1; v = 0; rdy = 0; fl = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("mrst_valid", 64'(mv[i]), 64'd0);
            check("mrst_opc",   64'(mo[i]), 64'd0);
            check("mrst_waddr", 64'(ma[i]), 64'd0);
            check("mrst_wen",   64'(mw[i]), 64'd0);
            mdl_clear(i);
            pushed[i] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_rdy1", 64'(er[1]), 64'd1);
        check("mrst_rdy0", 64'(er[0]), 64'd1);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 7, $urandom,
                 ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 31) == 0);
        end
        repeat (4) step(0, 32'h0, 5'd0, 0, 1, 0);
        #3;
        check("drain_q0", 64'(mdl_size(0)), 64'd0);
        check("drain_q1", 64'(mdl_size(1)), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
